// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: op codes, sequencer states and
// op classification helpers.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_NOT = 3'b010;
  localparam op_t OP_AND = 3'b011;
  localparam op_t OP_OR  = 3'b100;
  localparam op_t OP_XOR = 3'b101;
  localparam op_t OP_SLT = 3'b110;
  localparam op_t OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_arith(op_t op);
    return op inside {OP_ADD, OP_SUB, OP_SLT, OP_EQ};
  endfunction

  // slt and eq are both evaluated as a subtraction a - b.
  function automatic logic inverts_b(op_t op);
    return op inside {OP_SUB, OP_SLT, OP_EQ};
  endfunction

endpackage

// File: rtl/alu4_slice.sv
// Combinational 4-bit ALU slice; one instance serves every nibble of a word.
module alu4_slice
  import alu_pkg::*;
(
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  input  op_t        op,
  output logic [3:0] f4,
  output logic       cout,
  output logic       xb_msb,
  output logic       sum_msb
);

  logic [3:0] xb;
  logic [4:0] sum;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    xb      = b4 ^ {4{inverts_b(op)}};
    sum     = {1'b0, a4} + {1'b0, xb} + {4'b0000, cin};
    xb_msb  = xb[3];
    sum_msb = sum[3];
    f4      = sum[3:0];
    cout    = 1'b0;
    if (is_arith(op)) begin
      cout = sum[4];
    end else begin
      case (op)
        OP_NOT:  f4 = ~a4;
        OP_AND:  f4 = a4 & b4;
        OP_OR:   f4 = a4 | b4;
        OP_XOR:  f4 = a4 ^ b4;
        default: f4 = sum[3:0];
      endcase
    end
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// WIDTH-bit ALU sequenced through one 4-bit slice, LSB nibble first, with a
// valid/ready command input and a valid/ready result output.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_f,
  output logic             over_f,
  output logic             cout_f,
  output logic             less_f
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, over_q, over_d, cout_q, cout_d, less_q, less_d;

  logic [3:0]       a4, b4, f4;
  logic             s_cout, xb_msb, sum_msb;
  logic [WIDTH-1:0] res_acc, res_fin;
  logic             ovf, lt;

  assign a4 = 4'(a_q >> {idx_q, 2'b00});
  assign b4 = 4'(b_q >> {idx_q, 2'b00});

  alu4_slice u_slice (
    .a4      (a4),
    .b4      (b4),
    .cin     (carry_q),
    .op      (op_q),
    .f4      (f4),
    .cout    (s_cout),
    .xb_msb  (xb_msb),
    .sum_msb (sum_msb)
  );

  // Signed overflow and less-than are only meaningful on the MSB nibble.
  assign ovf     = (a4[3] == xb_msb) && (a4[3] != sum_msb);
  assign lt      = sum_msb ^ ovf;
  assign res_acc = res_q | ({{(WIDTH-4){1'b0}}, f4} << {idx_q, 2'b00});

  always_comb begin
    res_fin = res_acc;
    case (op_q)
      OP_SLT:  res_fin = {{(WIDTH-1){1'b0}}, lt};
      OP_EQ:   res_fin = {{(WIDTH-1){1'b0}}, (res_acc == '0)};
      default: res_fin = res_acc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    over_d  = over_q;
    cout_d  = cout_q;
    less_d  = less_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          idx_d   = '0;
          carry_d = inverts_b(op);
          op_d    = op;
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          zero_d  = 1'b0;
          over_d  = 1'b0;
          cout_d  = 1'b0;
          less_d  = 1'b0;
        end
      end
      S_RUN: begin
        carry_d = s_cout;
        idx_d   = idx_q + 1'b1;
        res_d   = res_acc;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          res_d   = res_fin;
          zero_d  = (res_fin == '0);
          cout_d  = (op_q == OP_ADD || op_q == OP_SUB) && s_cout;
          over_d  = (op_q == OP_ADD || op_q == OP_SUB) && ovf;
          less_d  = (op_q == OP_SUB || op_q == OP_SLT) && lt;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      over_q  <= 1'b0;
      cout_q  <= 1'b0;
      less_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      over_q  <= over_d;
      cout_q  <= cout_d;
      less_q  <= less_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign zero_f    = zero_q;
  assign over_f    = over_q;
  assign cout_f    = cout_q;
  assign less_f    = less_q;

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Multi-cycle sequencer that runs WIDTH-bit ALU operations through one shared 4-bit ALU slice, one nibble per clock, LSB first. Between nibbles it registers the carry, accumulates the result and flags, and presents the finished result on a valid/ready output handshake. It sits between the operand/command source (switch/keypad front end or a CPU-side requester) and the display/result consumer. Hardware is traded for latency: one 4-bit adder serves any 4-multiple word width.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 8.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command.
- op  in  3  000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
- a, b  in  WIDTH  operands, sampled only on acceptance.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- zero_f, over_f, cout_f, less_f  out  1 each  flags (see Operation).

## Operation
- States: IDLE, RUN, DONE. Nibble counter idx, 0..WIDTH/4-1.
- IDLE: in_ready=1. On in_valid&&in_ready, latch op, a, b; set idx=0; carry register = 1 for sub/slt/eq, 0 otherwise; clear the result accumulator; go to RUN.
- RUN: the slice computes nibble idx from latched operands and the carry register. The nibble is written into result[4*idx+:4], carry register <= slice cout, idx++. After the last nibble go to DONE.
- Arithmetic ops (add, sub, slt, eq) compute a + (b ^ {4{sub}}) + cin per nibble. Logic ops ignore carry.
- Final-nibble flags: cout_f = carry out of MSB nibble for add/sub (sub: 1 = no borrow), else 0. over_f = (a_msb==xb_msb)&&(a_msb!=sum_msb) for add/sub, else 0. less_f = sum_msb ^ overflow for sub/slt, else 0.
- slt: result = {0…, less}. eq: result = {0…, (a-b)==0}. Both report cout_f=0 and over_f=0.
- zero_f = (final result == 0) for every op.
- DONE: out_valid=1, result and flags stable. On out_ready go to IDLE. in_ready=0 in RUN and DONE, and in_valid is ignored there.
- Any rst_n low, including mid-RUN or mid-DONE, drops to IDLE immediately. The in-flight command is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, all flags=0, state IDLE, idx=0, carry=0.
- Latency: out_valid rises WIDTH/4 cycles after the acceptance edge (4 cycles for WIDTH=16).
- DONE→IDLE takes one edge after out_ready, and the next command is accepted on the following edge. Minimum issue interval is WIDTH/4+2 cycles.
- result and flags are registered outputs. They do not change while out_valid=1 and out_ready=0.
- Operand changes after acceptance have no effect.

## Structure
- Shared package alu_pkg holds the op code localparams (OP_ADD … OP_EQ), the state encoding (S_IDLE, S_RUN, S_DONE), and helper function is_arith(op).
- One sub-module, alu4_slice: combinational. Inputs a4, b4, cin, op. Outputs f4, cout, and the xb/sum MSB bits used for overflow. It is instantiated once.
- The top holds the FSM, idx counter ($clog2(WIDTH/4) bits), carry register, result shift/accumulate, and the flag logic.

## Test plan
- Add 0x7FFF + 0x0001 → result 0x8000, over_f=1, cout_f=0, zero_f=0, out_valid exactly 4 cycles after acceptance.
- Sub 0x0005 - 0x0005 → 0x0000, zero_f=1, cout_f=1, over_f=0. Sub 0x0003 - 0x0005 → 0xFFFE, cout_f=0, less_f=1.
- Slt a=0xFFFF, b=0x0001 → result 0x0001, less_f=1. Eq 0x1234, 0x1234 → 0x0001. Eq 0x1234, 0x1235 → 0x0000, zero_f=1.
- Xor 0xF0F0 ^ 0x0FF0 → 0xFF00, cout_f=0, over_f=0. Not a=0x00FF → 0xFF00.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and a → result/flags unchanged, in_ready=0, no second command taken. Release → IDLE next edge.
- Assert rst_n low after 2 nibbles of an add → out_valid=0 and in_ready=1 asynchronously. After release, add 0x0001 + 0x0001 → 0x0002 with no carry residue.
